// File: rtl/boxcar_pkg.sv
// rtl/boxcar_pkg.sv - shared types and sizing helpers for the boxcar decoder
package boxcar_pkg;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    RESYNC = 1'b1
  } state_t;

  localparam int ERR_COUNT_W = 8;

  // The moving sum of tap_size w-bit samples needs log2(tap_size) extra bits.
  function automatic int sum_width(input int tap_size, input int w);
    return $clog2(tap_size) + w;
  endfunction

endpackage

// File: rtl/sample_history.sv
// rtl/sample_history.sv - depth-deep sample shift register exposing only the oldest entry
module sample_history #(
  parameter int depth = 4,
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic [width-1:0] din,
  output logic [width-1:0] oldest
);

  logic [width-1:0] data [depth];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < depth; i++) data[i] <= '0;
    end else if (shift) begin
      data[0] <= din;
      for (int i = 1; i < depth; i++) data[i] <= data[i-1];
    end
  end

  assign oldest = data[depth-1];

endmodule

// File: rtl/boxcar_decoder.sv
// rtl/boxcar_decoder.sv - inverse of the tapSize-tap moving-sum filter
// BOXCAR_DEC_CHECK_EN enables consistency checking, RESYNC, err, err_count and in_sync.
module boxcar_decoder
  import boxcar_pkg::*;
#(
  parameter int tapSize = 4,
  parameter int width   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [$clog2(tapSize)+width-1:0]  in,
  output logic                              out_valid,
  output logic [width-1:0]                  out,
  output logic                              err,
  output logic                              in_sync,
  output logic [ERR_COUNT_W-1:0]            err_count
);

  localparam int S = sum_width(tapSize, width);

  logic [S-1:0]       y_prev;
  logic [width-1:0]   oldest;
  logic signed [S+1:0] d;
  logic               hist_shift;
  logic               hist_clear;

  // Two guard bits keep both the negative and the over-range result exact.
  assign d = $signed({2'b00, in}) - $signed({2'b00, y_prev})
           + $signed({{(S+2-width){1'b0}}, oldest});

  sample_history #(
    .depth (tapSize),
    .width (width)
  ) u_history (
    .clk    (clk),
    .reset  (reset),
    .clear  (hist_clear),
    .shift  (hist_shift),
    .din    (d[width-1:0]),
    .oldest (oldest)
  );

`ifdef BOXCAR_DEC_CHECK_EN

  state_t state;
  logic   in_range;

  assign in_range   = ~d[S+1] && (d[S:width] == '0);
  assign hist_shift = in_valid && (state == RUN) && in_range;
  assign hist_clear = in_valid && (state == RESYNC) && (in == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      y_prev    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      in_sync   <= 1'b1;
      err_count <= '0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      if (in_valid) begin
        case (state)
          RUN: begin
            if (in_range) begin
              out       <= d[width-1:0];
              out_valid <= 1'b1;
              y_prev    <= in;
            end else begin
              err     <= 1'b1;
              state   <= RESYNC;
              in_sync <= 1'b0;
              if (err_count != '1) err_count <= err_count + ERR_COUNT_W'(1);
            end
          end
          RESYNC: begin
            // A zero sum means every sample in the window was zero: history is known again.
            if (in == '0) begin
              y_prev    <= '0;
              out       <= '0;
              out_valid <= 1'b1;
              state     <= RUN;
              in_sync   <= 1'b1;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`else

  logic unused_d_hi;

  assign unused_d_hi = ^d[S+1:width];
  assign hist_shift  = in_valid;
  assign hist_clear  = 1'b0;
  assign err         = 1'b0;
  assign in_sync     = 1'b1;
  assign err_count   = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      y_prev    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out    <= d[width-1:0];
        y_prev <= in;
      end
    end
  end

`endif

endmodule

// File: tb/tb_boxcar_decoder.sv
// tb/tb_boxcar_decoder.sv - directed self-checking bench for boxcar_decoder
module tb_boxcar_decoder;

  localparam int TAP = 4;
  localparam int W   = 4;
  localparam int S   = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [S-1:0] in = '0;
  logic         out_valid;
  logic [W-1:0] out;
  logic         err;
  logic         in_sync;
  logic [7:0]   err_count;

  int tests = 0;
  int failures = 0;

  boxcar_decoder #(
    .tapSize (TAP),
    .width   (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in        (in),
    .out_valid (out_valid),
    .out       (out),
    .err       (err),
    .in_sync   (in_sync),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic beat(input int v);
    @(negedge clk);
    in_valid = 1'b1;
    in = S'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check(tag, out_valid, 0);
    end
  endtask

  task automatic expect_out(input string tag, input int v);
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out, v);
    check({tag, "_err"}, err, 0);
  endtask

  int seq_in  [5] = '{3, 8, 15, 16, 13};
  int seq_out [5] = '{3, 5, 7, 1, 0};
  int fs_in   [5] = '{15, 30, 45, 60, 60};

  initial begin
    do_reset();
    #1;
    check("rst_out", out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_in_sync", in_sync, 1);
    check("rst_err_count", err_count, 0);

    for (int i = 0; i < 5; i++) begin
      beat(seq_in[i]);
      expect_out($sformatf("seq%0d", i), seq_out[i]);
    end
    idle(1, "seq_tail_idle");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(fs_in[i]);
      expect_out($sformatf("full%0d", i), 15);
    end

    do_reset();
    beat(3);
    expect_out("gap0", 3);
    idle(2, "gap_idle_a");
    beat(8);
    expect_out("gap1", 5);
    idle(3, "gap_idle_b");
    beat(15);
    expect_out("gap2", 7);

    // Reset together with a valid beat: the beat is discarded.
    beat(16);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    in = 6'd13;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out", out, 0);
    check("midrst_err", err, 0);
    check("midrst_in_sync", in_sync, 1);
    check("midrst_err_count", err_count, 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;

`ifdef BOXCAR_DEC_CHECK_EN
    do_reset();
    beat(3);
    expect_out("inc0", 3);
    beat(40);
    check("inc_err", err, 1);
    check("inc_err_valid", out_valid, 0);
    check("inc_err_sync", in_sync, 0);
    check("inc_err_count", err_count, 1);
    beat(9);
    check("resync9_valid", out_valid, 0);
    check("resync9_err", err, 0);
    check("resync9_sync", in_sync, 0);
    beat(0);
    expect_out("relock", 0);
    check("relock_sync", in_sync, 1);
    beat(4);
    expect_out("relock4", 4);
    beat(6);
    expect_out("relock6", 2);

    do_reset();
    beat(8);
    expect_out("neg0", 8);
    beat(2);
    check("neg_err", err, 1);
    check("neg_err_valid", out_valid, 0);
    check("neg_err_count", err_count, 1);
    for (int i = 2; i <= 260; i++) begin
      beat(0);
      beat(40);
      if (i == 200) check("cnt200", err_count, 200);
      if (i == 255) check("cnt255", err_count, 255);
    end
    check("cnt_sat", err_count, 255);
    check("cnt_sat_err", err, 1);

    beat(0);
    beat(3);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst2_out", out, 0);
    check("rst2_valid", out_valid, 0);
    check("rst2_err", err, 0);
    check("rst2_sync", in_sync, 1);
    check("rst2_err_count", err_count, 0);
    @(negedge clk);
    reset = 1'b0;
`else
    do_reset();
    beat(3);
    expect_out("nochk0", 3);
    beat(40);
    expect_out("nochk1", 5);
    check("nochk_sync", in_sync, 1);
    check("nochk_err_count", err_count, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
